// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring algorithm on magnitudes.
// Define BOOTH_DIV_OVERFLOW_EN to add the overflow port and quotient saturation.
module booth_divider #(
   parameter int unsigned N = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero
`ifdef BOOTH_DIV_OVERFLOW_EN
   ,
   output logic           overflow
`endif
);

   localparam int unsigned CW = $clog2(2*N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t         state;
   logic [2*N-1:0] qreg;
   logic [N-1:0]   rreg;
   logic [N-1:0]   dmag;
   logic           sgn_dvd;
   logic           sgn_dvs;
   logic           zero_div;
   logic [CW-1:0]  count;

   logic [2*N-1:0] dvd_mag;
   logic [N-1:0]   dvs_mag;
   logic [N:0]     shifted;
   logic [N+1:0]   diff;
   logic [N-1:0]   rem_next;
   logic           qbit;
   logic           neg_q;
   logic [2*N-1:0] q_signed;
   logic [N-1:0]   r_fix;

   // 2N-bit unsigned magnitude keeps -2^(2N-1) exact
   always_comb begin
      dvd_mag = dividend[2*N-1] ? -dividend : dividend;
      dvs_mag = divisor[N-1] ? -divisor : divisor;
   end

   always_comb begin
      shifted  = {rreg, qreg[2*N-1]};
      diff     = {1'b0, shifted} - {2'b00, dmag};
      qbit     = ~diff[N+1];
      rem_next = qbit ? diff[N-1:0] : shifted[N-1:0];
   end

   always_comb begin
      neg_q    = sgn_dvd ^ sgn_dvs;
      q_signed = neg_q ? -qreg : qreg;
      r_fix    = sgn_dvd ? -rreg : rreg;
   end

`ifdef BOOTH_DIV_OVERFLOW_EN
   logic [2*N-1:0] pos_lim;
   logic [2*N-1:0] neg_lim;
   logic           ovf;
   logic [N-1:0]   q_sat;

   // Range test on the magnitude avoids the 2N-bit wrap of +2^(2N-1)
   always_comb begin
      pos_lim = {{(N+1){1'b0}}, {(N-1){1'b1}}};
      neg_lim = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
      ovf     = neg_q ? (qreg > neg_lim) : (qreg > pos_lim);
      q_sat   = neg_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         qreg        <= '0;
         rreg        <= '0;
         dmag        <= '0;
         sgn_dvd     <= 1'b0;
         sgn_dvs     <= 1'b0;
         zero_div    <= 1'b0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef BOOTH_DIV_OVERFLOW_EN
         overflow    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
`ifdef BOOTH_DIV_OVERFLOW_EN
                  overflow    <= 1'b0;
`endif
                  sgn_dvd     <= dividend[2*N-1];
                  sgn_dvs     <= divisor[N-1];
                  dmag        <= dvs_mag;
                  rreg        <= '0;
                  count       <= CW'(2*N);
                  if (divisor == '0) begin
                     // Raw dividend kept so its low bits become the remainder
                     zero_div <= 1'b1;
                     qreg     <= dividend;
                     state    <= FIX;
                  end else begin
                     zero_div <= 1'b0;
                     qreg     <= dvd_mag;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               qreg  <= {qreg[2*N-2:0], qbit};
               rreg  <= rem_next;
               count <= count - CW'(1);
               if (count == CW'(1)) state <= FIX;
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (zero_div) begin
                  quotient    <= '1;
                  remainder   <= qreg[N-1:0];
                  div_by_zero <= 1'b1;
               end else begin
`ifdef BOOTH_DIV_OVERFLOW_EN
                  quotient  <= ovf ? q_sat : q_signed[N-1:0];
                  overflow  <= ovf;
`else
                  quotient  <= q_signed[N-1:0];
`endif
                  remainder <= r_fix;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider (N=4, default build without overflow port).
module tb_booth_divider;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   booth_divider #(.N(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   // Pulses start for one sampling edge and returns the edge count until done (-1 on timeout).
   task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs, output int lat);
      @(negedge clock);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat   = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({quotient, remainder, busy, done, div_by_zero} !== 11'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got q=%h r=%h b=%b d=%b z=%b expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int lat;
      @(negedge clock);
      dividend = 8'd21;
      divisor  = 4'd4;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_bad++;
         $display("FAIL basic_busy: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            break;
         end
      end
      n_cmp++;
      if (lat !== 9) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d expected 9", lat);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero, busy} !== {4'h5, 4'h1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL basic_21_4: got q=%h r=%h z=%b b=%b expected q=5 r=1 z=0 b=0",
                  quotient, remainder, div_by_zero, busy);
      end
      @(negedge clock);
      n_cmp++;
      if ({done, quotient, remainder} !== {1'b0, 4'h5, 4'h1}) begin
         n_bad++;
         $display("FAIL basic_hold: got done=%b q=%h r=%h expected done=0 q=5 r=1",
                  done, quotient, remainder);
      end
   endtask

   task automatic test_signed;
      int lat;
      run_op(8'hEB, 4'd4, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'hB, 4'hF}) begin
         n_bad++;
         $display("FAIL signed_m21_4: got lat=%0d q=%h r=%h expected lat=9 q=b r=f", lat, quotient, remainder);
      end
      run_op(8'd21, 4'hC, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'hB, 4'h1}) begin
         n_bad++;
         $display("FAIL signed_21_m4: got lat=%0d q=%h r=%h expected lat=9 q=b r=1", lat, quotient, remainder);
      end
      run_op(8'hEB, 4'hC, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'h5, 4'hF}) begin
         n_bad++;
         $display("FAIL signed_m21_m4: got lat=%0d q=%h r=%h expected lat=9 q=5 r=f", lat, quotient, remainder);
      end
   endtask

   task automatic test_wrap;
      int lat;
      run_op(8'd50, 4'hD, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder, div_by_zero} !== {1'b1, 4'h0, 4'h2, 1'b0}) begin
         n_bad++;
         $display("FAIL wrap_50_m3: got lat=%0d q=%h r=%h z=%b expected lat=9 q=0 r=2 z=0",
                  lat, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_min_dividend;
      int lat;
      run_op(8'h80, 4'd7, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'hE, 4'hE}) begin
         n_bad++;
         $display("FAIL min_m128_7: got lat=%0d q=%h r=%h expected lat=9 q=e r=e", lat, quotient, remainder);
      end
      run_op(8'h80, 4'hF, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'h0, 4'h0}) begin
         n_bad++;
         $display("FAIL min_m128_m1: got lat=%0d q=%h r=%h expected lat=9 q=0 r=0", lat, quotient, remainder);
      end
   endtask

   task automatic test_div_zero;
      int lat;
      run_op(8'd7, 4'd0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_bad++;
         $display("FAIL divzero_latency: got %0d expected 1", lat);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero, busy} !== {4'hF, 4'h7, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL divzero_7_0: got q=%h r=%h z=%b b=%b expected q=f r=7 z=1 b=0",
                  quotient, remainder, div_by_zero, busy);
      end
      run_op(8'd9, 4'd3, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder, div_by_zero} !== {1'b1, 4'h3, 4'h0, 1'b0}) begin
         n_bad++;
         $display("FAIL divzero_clear: got lat=%0d q=%h r=%h z=%b expected lat=9 q=3 r=0 z=0",
                  lat, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_ignore_start;
      int edge_done;
      @(negedge clock);
      dividend = 8'd21;
      divisor  = 4'd4;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      dividend = 8'd9;
      divisor  = 4'd3;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      edge_done = -1;
      for (int k = 3; k <= 40; k++) begin
         @(negedge clock);
         if (done) begin
            edge_done = k;
            break;
         end
      end
      n_cmp++;
      if ({edge_done == 9, quotient, remainder} !== {1'b1, 4'h5, 4'h1}) begin
         n_bad++;
         $display("FAIL ignore_start: got edge=%0d q=%h r=%h expected edge=9 q=5 r=1",
                  edge_done, quotient, remainder);
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL ignore_no_queue: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clock);
      dividend = 8'd21;
      divisor  = 4'd4;
      start    = 1'b1;
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            break;
         end
      end
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'h5, 4'h1}) begin
         n_bad++;
         $display("FAIL b2b_first: got lat=%0d q=%h r=%h expected lat=9 q=5 r=1", lat, quotient, remainder);
      end
      dividend = 8'd50;
      divisor  = 4'hD;
      @(negedge clock);
      start = 1'b0;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_bad++;
         $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            break;
         end
      end
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'h0, 4'h2}) begin
         n_bad++;
         $display("FAIL b2b_second: got lat=%0d q=%h r=%h expected lat=9 q=0 r=2", lat, quotient, remainder);
      end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      @(negedge clock);
      dividend = 8'd21;
      divisor  = 4'd4;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      dividend = 8'd9;
      divisor  = 4'd3;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({quotient, remainder, busy, done, div_by_zero} !== 11'd0) begin
         n_bad++;
         $display("FAIL midrun_reset: got q=%h r=%h b=%b d=%b z=%b expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL midrun_abandon: got busy=%b done=%b expected 0 0", busy, done);
      end
      run_op(8'd21, 4'd4, lat);
      n_cmp++;
      if ({lat == 9, quotient, remainder} !== {1'b1, 4'h5, 4'h1}) begin
         n_bad++;
         $display("FAIL midrun_fresh: got lat=%0d q=%h r=%h expected lat=9 q=5 r=1", lat, quotient, remainder);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_wrap;
      test_min_dividend;
      test_div_zero;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
